hdc_argmax: RTL and testbench

//  Downstream stage of the partial dot-product unit. Consumes one FP16 class score per
//  max_en strobe (accum_dout), tracks the running maximum and its class label across
//  NUM_C classes, and publishes the predicted label on frame end via a valid/ready

---
 rtl/hdc_argmax.sv | 206 ++++++++++++++++++++
 tb/tb_hdc_argmax.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/hdc_argmax.sv
// hdc_argmax -- running argmax over the NUM_C FP16 class scores of one frame.
//
// One score arrives per score_en strobe, in label order. The block tracks the
// best score and its label. On frame_done it publishes the result through a
// valid/ready register stage. That stage is double-buffered: while a result
// waits for the consumer, the next frame keeps accumulating in the working
// registers.
//
// Optional feature macro: HDC_ARGMAX_TOP2_EN
//   When defined, the block also tracks the runner-up class and adds the
//   outputs pred_label2 and pred_score2.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   clr                       clear working max/counter (output stage untouched)
//   score_en, score           score strobe and FP16 class score
//   frame_done                frame end: publish, then clear working state
//   pred_valid/pred_ready     output handshake
//   pred_label, pred_score    argmax label and winning raw FP16 score
//   pred_label2, pred_score2  runner-up (only with HDC_ARGMAX_TOP2_EN)
//   err_count                 sticky: bad score count at frame end, or strobe past NUM_C
//   err_overrun               sticky: frame_done while a result was still held
module hdc_argmax #(
  parameter int NUM_C = 10,
  parameter int ACC_W = 16,
  parameter int LBL_W = $clog2(NUM_C)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             score_en,
  input  logic [ACC_W-1:0] score,
  input  logic             frame_done,
  output logic             pred_valid,
  input  logic             pred_ready,
  output logic [LBL_W-1:0] pred_label,
  output logic [ACC_W-1:0] pred_score,
`ifdef HDC_ARGMAX_TOP2_EN
  output logic [LBL_W-1:0] pred_label2,
  output logic [ACC_W-1:0] pred_score2,
`endif
  output logic             err_count,
  output logic             err_overrun
);

  if (ACC_W != 16) begin : g_bad_acc_w
    $error("hdc_argmax: ACC_W must be 16 (FP16 scores only)");
  end

  localparam int CNT_W = $clog2(NUM_C + 1);
  localparam logic [CNT_W-1:0] NUM_C_C = CNT_W'(NUM_C);
  localparam logic [ACC_W-1:0] NEG_INF = 16'hFC00;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  // Map FP16 to an unsigned key whose integer order matches numeric order.
  // Both zeros map to the key of +0. Every NaN maps to key 0, so a NaN loses
  // to all other values.
  function automatic logic [ACC_W-1:0] fp_key(input logic [ACC_W-1:0] x);
    if (x[14:0] == 15'd0)                   fp_key = 16'h8000;
    else if (&x[14:10] && (x[9:0] != 10'd0)) fp_key = '0;
    else if (x[15])                         fp_key = ~x;
    else                                    fp_key = x ^ 16'h8000;
  endfunction

  // Working state
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic             any, nxt_any;
  logic [ACC_W-1:0] best_key, nxt_key;
  logic [ACC_W-1:0] best_raw, nxt_raw;
  logic [LBL_W-1:0] best_lbl, nxt_lbl;
`ifdef HDC_ARGMAX_TOP2_EN
  logic             any2, nxt_any2;
  logic [ACC_W-1:0] key2, nxt_key2;
  logic [ACC_W-1:0] raw2, nxt_raw2;
  logic [LBL_W-1:0] lbl2, nxt_lbl2;
`endif

  logic [0:0]       state;
  logic             take, ovf, load;
  logic [ACC_W-1:0] k;
  logic [LBL_W-1:0] lbl_in;

  // clr wins over a same-cycle score, so the score is taken only without clr.
  assign take   = score_en && !clr && (cnt != NUM_C_C);
  assign ovf    = score_en && !clr && (cnt == NUM_C_C);
  assign k      = fp_key(score);
  assign lbl_in = cnt[LBL_W-1:0];

  // nxt_* is the working state with this cycle's score folded in. A
  // frame_done in the same cycle publishes from nxt_*, so that last score
  // counts toward the result.
  always_comb begin
    nxt_cnt = cnt;
    nxt_any = any;
    nxt_key = best_key;
    nxt_raw = best_raw;
    nxt_lbl = best_lbl;
`ifdef HDC_ARGMAX_TOP2_EN
    nxt_any2 = any2;
    nxt_key2 = key2;
    nxt_raw2 = raw2;
    nxt_lbl2 = lbl2;
`endif
    if (take) begin
      nxt_cnt = cnt + CNT_W'(1);
      // Only a strictly greater key replaces the best, so on a tie the
      // lower label keeps the lead.
      if (!any || (k > best_key)) begin
        nxt_any = 1'b1;
        nxt_key = k;
        nxt_raw = score;
        nxt_lbl = lbl_in;
`ifdef HDC_ARGMAX_TOP2_EN
        // The displaced best becomes the runner-up.
        if (any) begin
          nxt_any2 = 1'b1;
          nxt_key2 = best_key;
          nxt_raw2 = best_raw;
          nxt_lbl2 = best_lbl;
        end
      end else if (!any2 || (k > key2)) begin
        nxt_any2 = 1'b1;
        nxt_key2 = k;
        nxt_raw2 = score;
        nxt_lbl2 = lbl_in;
`endif
      end
    end
  end

  assign pred_valid = (state == ST_FULL);
  // Accept a new result when the slot is empty, or when it drains in the same cycle.
  assign load       = frame_done && (!pred_valid || pred_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      any         <= 1'b0;
      best_key    <= '0;
      best_raw    <= NEG_INF;
      best_lbl    <= '0;
      state       <= ST_EMPTY;
      pred_label  <= '0;
      pred_score  <= NEG_INF;
      err_count   <= 1'b0;
      err_overrun <= 1'b0;
`ifdef HDC_ARGMAX_TOP2_EN
      any2        <= 1'b0;
      key2        <= '0;
      raw2        <= NEG_INF;
      lbl2        <= '0;
      pred_label2 <= '0;
      pred_score2 <= NEG_INF;
`endif
    end else begin
      // Working registers. The cleared state also serves as the empty-frame
      // result: label 0 with score -inf.
      if (clr || frame_done) begin
        cnt      <= '0;
        any      <= 1'b0;
        best_key <= '0;
        best_raw <= NEG_INF;
        best_lbl <= '0;
`ifdef HDC_ARGMAX_TOP2_EN
        any2     <= 1'b0;
        key2     <= '0;
        raw2     <= NEG_INF;
        lbl2     <= '0;
`endif
      end else begin
        cnt      <= nxt_cnt;
        any      <= nxt_any;
        best_key <= nxt_key;
        best_raw <= nxt_raw;
        best_lbl <= nxt_lbl;
`ifdef HDC_ARGMAX_TOP2_EN
        any2     <= nxt_any2;
        key2     <= nxt_key2;
        raw2     <= nxt_raw2;
        lbl2     <= nxt_lbl2;
`endif
      end

      if (ovf || (frame_done && (nxt_cnt != NUM_C_C)))
        err_count <= 1'b1;
      if (frame_done && pred_valid && !pred_ready)
        err_overrun <= 1'b1;

      // Output stage
      if (load) begin
        state       <= ST_FULL;
        pred_label  <= nxt_lbl;
        pred_score  <= nxt_raw;
`ifdef HDC_ARGMAX_TOP2_EN
        pred_label2 <= nxt_lbl2;
        pred_score2 <= nxt_raw2;
`endif
      end else if (pred_valid && pred_ready) begin
        state <= ST_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_hdc_argmax.sv
// Directed bench for hdc_argmax. Each check compares against a hand-computed constant.
module tb_hdc_argmax;
  logic        clk = 1'b0;
  logic        rst, clr, score_en, frame_done, pred_ready;
  logic [15:0] score;
  logic        pred_valid, err_count, err_overrun;
  logic [3:0]  pred_label;
  logic [15:0] pred_score;
`ifdef HDC_ARGMAX_TOP2_EN
  logic [3:0]  pred_label2;
  logic [15:0] pred_score2;
`endif

  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] fr [10];

  always #5 clk = ~clk;

  hdc_argmax #(.NUM_C(10), .ACC_W(16)) dut (
    .clk(clk), .rst(rst), .clr(clr), .score_en(score_en), .score(score),
    .frame_done(frame_done), .pred_valid(pred_valid), .pred_ready(pred_ready),
    .pred_label(pred_label), .pred_score(pred_score),
`ifdef HDC_ARGMAX_TOP2_EN
    .pred_label2(pred_label2), .pred_score2(pred_score2),
`endif
    .err_count(err_count), .err_overrun(err_overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All driving and sampling is done on the negedge.
  task automatic push(input logic [15:0] s);
    score = s; score_en = 1'b1;
    @(negedge clk);
    score_en = 1'b0;
  endtask

  task automatic send(input int n);
    for (int i = 0; i < n; i++) push(fr[i]);
  endtask

  task automatic done_t();
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
  endtask

  task automatic accept();
    pred_ready = 1'b1;
    @(negedge clk);
    pred_ready = 1'b0;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_valid"}, 32'(pred_valid), 0);
    chk({t, "_label"}, 32'(pred_label), 0);
    chk({t, "_score"}, 32'(pred_score), 32'hFC00);
    chk({t, "_errc"},  32'(err_count), 0);
    chk({t, "_erro"},  32'(err_overrun), 0);
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; score_en = 1'b0; frame_done = 1'b0;
    pred_ready = 1'b0; score = '0;
    @(negedge clk);
    do_rst();
    chk_reset("rst");

    // T1: basic frame, max 2.0 at class 1; runner-up 1.5 at class 9
    fr = '{16'h3C00, 16'h4000, 16'hC000, 16'h3800, 16'h3400,
           16'h0000, 16'h8000, 16'hBC00, 16'h3A00, 16'h3E00};
    send(10); done_t();
    chk("t1_valid", 32'(pred_valid), 1);
    chk("t1_label", 32'(pred_label), 1);
    chk("t1_score", 32'(pred_score), 32'h4000);
    chk("t1_errc",  32'(err_count), 0);
`ifdef HDC_ARGMAX_TOP2_EN
    chk("t1_label2", 32'(pred_label2), 9);
    chk("t1_score2", 32'(pred_score2), 32'h3E00);
`endif
    accept();
    chk("t1_drain", 32'(pred_valid), 0);

    // T2: tie at classes 2 and 7 -> lower label wins
    fr = '{16'h3C00, 16'h3C00, 16'h4500, 16'h3C00, 16'h3C00,
           16'h3C00, 16'h3C00, 16'h4500, 16'h3C00, 16'h3C00};
    send(10); done_t();
    chk("t2_label", 32'(pred_label), 2);
    chk("t2_score", 32'(pred_score), 32'h4500);
`ifdef HDC_ARGMAX_TOP2_EN
    chk("t2_label2", 32'(pred_label2), 7);
    chk("t2_score2", 32'(pred_score2), 32'h4500);
`endif
    accept();

    // T3: NaN at class 0; -0 at 4 and +0 at 6 tie, lower label wins
    fr = '{16'h7E01, 16'hBC00, 16'hC000, 16'hBC00, 16'h8000,
           16'hC400, 16'h0000, 16'hBC00, 16'hC000, 16'hBC00};
    send(10); done_t();
    chk("t3_label", 32'(pred_label), 4);
    chk("t3_score", 32'(pred_score), 32'h8000);
`ifdef HDC_ARGMAX_TOP2_EN
    chk("t3_label2", 32'(pred_label2), 6);
    chk("t3_score2", 32'(pred_score2), 32'h0000);
`endif
    accept();

    // T4: held result, then same-cycle drain+publish, then overrun
    fr = '{16'h3C00, 16'h4000, 16'hC000, 16'h3800, 16'h3400,
           16'h0000, 16'h8000, 16'hBC00, 16'h3A00, 16'h3E00};
    send(10); done_t();
    repeat (3) @(negedge clk);
    chk("t4_hold_valid", 32'(pred_valid), 1);
    chk("t4_hold_label", 32'(pred_label), 1);
    fr = '{16'h3C00, 16'h3C00, 16'h4500, 16'h3C00, 16'h3C00,
           16'h3C00, 16'h3C00, 16'h4500, 16'h3C00, 16'h3C00};
    send(10);
    frame_done = 1'b1; pred_ready = 1'b1;
    @(negedge clk);
    frame_done = 1'b0; pred_ready = 1'b0;
    chk("t4_swap_valid", 32'(pred_valid), 1);
    chk("t4_swap_label", 32'(pred_label), 2);
    chk("t4_swap_erro",  32'(err_overrun), 0);
    fr = '{16'h7E01, 16'hBC00, 16'hC000, 16'hBC00, 16'h8000,
           16'hC400, 16'h0000, 16'hBC00, 16'hC000, 16'hBC00};
    send(10); done_t();
    chk("t4_ovr_erro",  32'(err_overrun), 1);
    chk("t4_ovr_label", 32'(pred_label), 2);
    chk("t4_ovr_score", 32'(pred_score), 32'h4500);
    chk("t4_ovr_valid", 32'(pred_valid), 1);
    accept();
    chk("t4_drain", 32'(pred_valid), 0);

    // T5a: 11 strobes -> err_count on the 11th
    do_rst();
    fr = '{16'h3C00, 16'h4000, 16'hC000, 16'h3800, 16'h3400,
           16'h0000, 16'h8000, 16'hBC00, 16'h3A00, 16'h3E00};
    send(10);
    chk("t5_pre11_errc", 32'(err_count), 0);
    push(16'h4800);
    chk("t5_11_errc", 32'(err_count), 1);
    done_t();
    chk("t5_11_label", 32'(pred_label), 1);
    accept();

    // T5b: 9 strobes then frame_done
    do_rst();
    send(9); done_t();
    chk("t5_9_errc",  32'(err_count), 1);
    chk("t5_9_label", 32'(pred_label), 1);
    accept();

    // T5c: clr with frame_done publishes, then next frame starts at label 0
    do_rst();
    fr = '{16'h3C00, 16'h3C00, 16'h4500, 16'h3C00, 16'h3C00,
           16'h3C00, 16'h3C00, 16'h4500, 16'h3C00, 16'h3C00};
    send(10);
    clr = 1'b1; frame_done = 1'b1;
    @(negedge clk);
    clr = 1'b0; frame_done = 1'b0;
    chk("t5_clr_valid", 32'(pred_valid), 1);
    chk("t5_clr_label", 32'(pred_label), 2);
    accept();
    fr = '{16'h4800, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00,
           16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00};
    send(10); done_t();
    chk("t5_next_label", 32'(pred_label), 0);
    chk("t5_next_score", 32'(pred_score), 32'h4800);
    chk("t5_next_errc",  32'(err_count), 0);
    accept();

    // clr mid-frame discards partial scores
    fr = '{16'h3C00, 16'h4000, 16'h5000, 16'h3800, 16'h3400,
           16'h0000, 16'h8000, 16'hBC00, 16'h3A00, 16'h3E00};
    send(3);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    fr = '{16'h3C00, 16'h3C00, 16'h4500, 16'h3C00, 16'h3C00,
           16'h3C00, 16'h3C00, 16'h4500, 16'h3C00, 16'h3C00};
    send(10); done_t();
    chk("clr_mid_label", 32'(pred_label), 2);
    chk("clr_mid_errc",  32'(err_count), 0);
    accept();

    // score_en with frame_done: the last score is included
    fr = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00,
           16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h4A00};
    send(9);
    score = fr[9]; score_en = 1'b1; frame_done = 1'b1;
    @(negedge clk);
    score_en = 1'b0; frame_done = 1'b0;
    chk("last_label", 32'(pred_label), 9);
    chk("last_score", 32'(pred_score), 32'h4A00);
    chk("last_errc",  32'(err_count), 0);
`ifdef HDC_ARGMAX_TOP2_EN
    chk("last_label2", 32'(pred_label2), 0);
    chk("last_score2", 32'(pred_score2), 32'h3C00);
`endif
    accept();

    // Empty frame: label 0, score -inf, err_count
    done_t();
    chk("empty_label", 32'(pred_label), 0);
    chk("empty_score", 32'(pred_score), 32'hFC00);
    chk("empty_errc",  32'(err_count), 1);
    accept();

    // T6: rst mid-frame, with a held result and sticky errors
    fr = '{16'h3C00, 16'h4000, 16'hC000, 16'h3800, 16'h3400,
           16'h0000, 16'h8000, 16'hBC00, 16'h3A00, 16'h3E00};
    send(10); done_t();
    send(5);
    do_rst();
    chk_reset("t6");
    fr = '{16'h3C00, 16'h3C00, 16'h4500, 16'h3C00, 16'h3C00,
           16'h3C00, 16'h3C00, 16'h4500, 16'h3C00, 16'h3C00};
    send(10); done_t();
    chk("t6_label", 32'(pred_label), 2);
    chk("t6_errc",  32'(err_count), 0);
    accept();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
